// File: rtl/game_pkg.sv
// Shared definitions for the snowball/fireball gameplay screen: FSM state
// encoding, default gameplay tuning, renderer colours and a small
// distance helper used by the collision detectors.
package game_pkg;

  // Gameplay FSM states
  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_COOL = 2'd1,
    ST_WON  = 2'd2,
    ST_LOST = 2'd3
  } game_state_e;

  // Default gameplay tuning
  localparam logic [1:0] LIFE_INIT_DEF = 2'd3;
  localparam logic [2:0] CD_TICKS_DEF  = 3'd6;
  localparam logic [6:0] GOAL_X_DEF    = 7'd90;
  localparam logic [5:0] GOAL_Y_DEF    = 6'd58;
  localparam logic [7:0] HIT_R_DEF     = 8'd3;

  // 12-bit RGB colours shared with the pixel renderer
  localparam logic [11:0] COL_BG    = 12'h000;
  localparam logic [11:0] COL_SNOW  = 12'hFFF;
  localparam logic [11:0] COL_FIRE  = 12'hF40;
  localparam logic [11:0] COL_GOAL  = 12'h0F0;
  localparam logic [11:0] COL_HEART = 12'hF08;

  // Absolute difference of two zero-extended coordinates. Inputs are at
  // most 7 significant bits, so the signed 8-bit difference never overflows.
  function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    diff = a - b;
    if (diff[7]) begin
      abs_diff8 = 8'd0 - diff;
    end else begin
      abs_diff8 = diff;
    end
  endfunction

endpackage

// File: rtl/hit_detect.sv
// Combinational collision test of one fireball against the snowball:
// a hit is declared when both |dx| and |dy| are within HIT_R.
module hit_detect
  import game_pkg::*;
#(
  parameter logic [7:0] HIT_R = HIT_R_DEF
) (
  input  logic [6:0] char_x_i,
  input  logic [5:0] char_y_i,
  input  logic [6:0] fire_x_i,
  input  logic [5:0] fire_y_i,
  output logic       hit_o
);

  logic [7:0] dx_s;
  logic [7:0] dy_s;

  assign dx_s  = abs_diff8({1'b0, char_x_i}, {1'b0, fire_x_i});
  assign dy_s  = abs_diff8({2'b00, char_y_i}, {2'b00, fire_y_i});
  assign hit_o = (dx_s <= HIT_R) && (dy_s <= HIT_R);

endmodule

// File: rtl/game_ctrl.sv
// Gameplay sequencer: on every frame tick checks the snowball against four
// fireballs and the goal corner, then updates lives, the post-hit cooldown
// and the win/lose outcome. All outputs are registered.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [1:0] LIFE_INIT = LIFE_INIT_DEF,
  parameter logic [2:0] CD_TICKS  = CD_TICKS_DEF,
  parameter logic [6:0] GOAL_X    = GOAL_X_DEF,
  parameter logic [5:0] GOAL_Y    = GOAL_Y_DEF,
  parameter logic [7:0] HIT_R     = HIT_R_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic [6:0] char_x,
  input  logic [5:0] char_y,
  input  logic [6:0] fire1_x,
  input  logic [5:0] fire1_y,
  input  logic [6:0] fire2_x,
  input  logic [5:0] fire2_y,
  input  logic [6:0] fire3_x,
  input  logic [5:0] fire3_y,
  input  logic [6:0] fire4_x,
  input  logic [5:0] fire4_y,
  output logic [1:0] life,
  output logic       win,
  output logic       lose,
  output logic       cooldown,
  output logic [2:0] cd_cnt,
  output logic       freeze,
  output logic       hit_pulse
);

  logic [6:0] fire_x_s [4];
  logic [5:0] fire_y_s [4];
  logic [3:0] hit_vec_s;
  logic       any_hit_s;
  logic       at_goal_s;

  game_state_e state_q, state_d;
  logic [1:0]  life_q, life_d;
  logic [2:0]  cd_q, cd_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic        cool_q, cool_d;
  logic        freeze_q, freeze_d;
  logic        pulse_q, pulse_d;

  assign fire_x_s[0] = fire1_x;
  assign fire_x_s[1] = fire2_x;
  assign fire_x_s[2] = fire3_x;
  assign fire_x_s[3] = fire4_x;
  assign fire_y_s[0] = fire1_y;
  assign fire_y_s[1] = fire2_y;
  assign fire_y_s[2] = fire3_y;
  assign fire_y_s[3] = fire4_y;

  for (genvar g = 0; g < 4; g++) begin : g_hit
    hit_detect #(
      .HIT_R(HIT_R)
    ) u_hit (
      .char_x_i(char_x),
      .char_y_i(char_y),
      .fire_x_i(fire_x_s[g]),
      .fire_y_i(fire_y_s[g]),
      .hit_o   (hit_vec_s[g])
    );
  end

  // Overlapping fireballs collapse into a single hit event
  assign any_hit_s = |hit_vec_s;
  assign at_goal_s = (char_x >= GOAL_X) && (char_y >= GOAL_Y);

  // Next-state and next-output computation for the gameplay FSM
  always_comb begin
    state_d = state_q;
    life_d  = life_q;
    cd_d    = cd_q;
    win_d   = win_q;
    lose_d  = lose_q;
    cool_d  = cool_q;
    pulse_d = 1'b0;

    if (restart) begin
      // Level-sensitive restart pins the block in its start-of-game values
      state_d = ST_PLAY;
      life_d  = LIFE_INIT;
      cd_d    = 3'd0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      cool_d  = 1'b0;
    end else if (frame_tick) begin
      case (state_q)
        ST_PLAY: begin
          if (at_goal_s) begin
            // Reaching the goal wins even if a fireball touches this tick
            state_d = ST_WON;
            win_d   = 1'b1;
          end else if (any_hit_s) begin
            pulse_d = 1'b1;
            if (life_q <= 2'd1) begin
              state_d = ST_LOST;
              life_d  = 2'd0;
              lose_d  = 1'b1;
            end else begin
              state_d = ST_COOL;
              life_d  = life_q - 2'd1;
              cd_d    = CD_TICKS;
              cool_d  = 1'b1;
            end
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_COOL: begin
          // Invulnerable: hits are ignored while the counter runs down
          if (at_goal_s) begin
            state_d = ST_WON;
            win_d   = 1'b1;
            cd_d    = 3'd0;
            cool_d  = 1'b0;
          end else if (cd_q <= 3'd1) begin
            state_d = ST_PLAY;
            cd_d    = 3'd0;
            cool_d  = 1'b0;
          end else begin
            cd_d = cd_q - 3'd1;
          end
        end
        ST_WON: begin
          state_d = ST_WON;
        end
        ST_LOST: begin
          state_d = ST_LOST;
        end
        default: begin
          // Unreachable encoding: recover to a clean new game
          state_d = ST_PLAY;
          life_d  = LIFE_INIT;
          cd_d    = 3'd0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          cool_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    freeze_d = win_d | lose_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_PLAY;
      life_q   <= LIFE_INIT;
      cd_q     <= 3'd0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      cool_q   <= 1'b0;
      freeze_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      life_q   <= life_d;
      cd_q     <= cd_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      cool_q   <= cool_d;
      freeze_q <= freeze_d;
      pulse_q  <= pulse_d;
    end
  end

  assign life      = life_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign cooldown  = cool_q;
  assign cd_cnt    = cd_q;
  assign freeze    = freeze_q;
  assign hit_pulse = pulse_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios followed by random
// play, all checked against a behavioural model of the game rules.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, restart, frame_tick;
  logic [6:0] char_x, fire1_x, fire2_x, fire3_x, fire4_x;
  logic [5:0] char_y, fire1_y, fire2_y, fire3_y, fire4_y;
  logic [1:0] life;
  logic       win, lose, cooldown, freeze, hit_pulse;
  logic [2:0] cd_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: lives, cooldown ticks remaining, outcome flags
  int m_life, m_cd, m_win, m_lose, m_pulse;

  game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .char_x(char_x), .char_y(char_y),
    .fire1_x(fire1_x), .fire1_y(fire1_y), .fire2_x(fire2_x), .fire2_y(fire2_y),
    .fire3_x(fire3_x), .fire3_y(fire3_y), .fire4_x(fire4_x), .fire4_y(fire4_y),
    .life(life), .win(win), .lose(lose), .cooldown(cooldown), .cd_cnt(cd_cnt),
    .freeze(freeze), .hit_pulse(hit_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit touches(input int fx, input int fy);
    return (iabs(int'(char_x) - fx) <= 3) && (iabs(int'(char_y) - fy) <= 3);
  endfunction

  // Apply the game rules to the inputs present at this clock edge
  task automatic model_update();
    bit hit, goal;
    hit = touches(fire1_x, fire1_y) || touches(fire2_x, fire2_y) ||
          touches(fire3_x, fire3_y) || touches(fire4_x, fire4_y);
    goal = (char_x >= 7'd90) && (char_y >= 6'd58);
    m_pulse = 0;
    if (reset || restart) begin
      m_life = 3; m_cd = 0; m_win = 0; m_lose = 0;
    end else if (frame_tick) begin
      if (m_win != 0 || m_lose != 0) begin
        m_life = m_life;
      end else if (goal) begin
        m_win = 1; m_cd = 0;
      end else if (m_cd > 0) begin
        m_cd = m_cd - 1;
      end else if (hit) begin
        m_pulse = 1;
        if (m_life <= 1) begin
          m_life = 0; m_lose = 1;
        end else begin
          m_life = m_life - 1; m_cd = 6;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("life", life, m_life);
    check_val("win", win, m_win);
    check_val("lose", lose, m_lose);
    check_val("cooldown", cooldown, (m_cd > 0) ? 1 : 0);
    check_val("cd_cnt", cd_cnt, m_cd);
    check_val("freeze", freeze, (m_win != 0 || m_lose != 0) ? 1 : 0);
    check_val("hit_pulse", hit_pulse, m_pulse);
  endtask

  task automatic cycle(input logic t);
    frame_tick = t;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // One frame tick followed by an idle cycle
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1);
      cycle(1'b0);
    end
  endtask

  task automatic fires_away();
    fire1_x = 7'd50; fire1_y = 6'd30; fire2_x = 7'd50; fire2_y = 6'd30;
    fire3_x = 7'd50; fire3_y = 6'd30; fire4_x = 7'd50; fire4_y = 6'd30;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cycle(1'b1);
    restart = 1'b0;
    cycle(1'b0);
  endtask

  function automatic logic [6:0] near7(input int c);
    int v;
    v = c + int'($urandom_range(0, 8)) - 4;
    if (v < 0) v = 0;
    if (v > 127) v = 127;
    return 7'(v);
  endfunction

  function automatic logic [5:0] near6(input int c);
    int v;
    v = c + int'($urandom_range(0, 8)) - 4;
    if (v < 0) v = 0;
    if (v > 63) v = 63;
    return 6'(v);
  endfunction

  initial begin
    reset = 1'b1; restart = 1'b0; frame_tick = 1'b0;
    char_x = 7'd10; char_y = 6'd7;
    fires_away();
    m_life = 3; m_cd = 0; m_win = 0; m_lose = 0; m_pulse = 0;

    // Reset state
    cycle(1'b0);
    reset = 1'b0;
    check_val("reset_life", life, 3);

    // Idle play, no contact
    tick_n(10);
    check_val("idle_life", life, 3);

    // Corner-distance hit: |dx| = |dy| = 3
    fire1_x = 7'd13; fire1_y = 6'd10;
    cycle(1'b1);
    check_val("hit_pulse_on", hit_pulse, 1);
    check_val("hit_life", life, 2);
    check_val("hit_cd", cd_cnt, 6);
    cycle(1'b0);
    check_val("hit_pulse_off", hit_pulse, 0);
    // Overlap held through cooldown costs nothing more
    tick_n(6);
    check_val("cool_end_cd", cd_cnt, 0);
    check_val("cool_end_life", life, 2);
    // |dx| = 4: just out of reach
    fire1_x = 7'd14; fire1_y = 6'd7;
    tick_n(2);
    check_val("miss_life", life, 2);

    // All four fireballs on the snowball in one tick
    fire1_x = 7'd10; fire1_y = 6'd7; fire2_x = 7'd10; fire2_y = 6'd7;
    fire3_x = 7'd10; fire3_y = 6'd7; fire4_x = 7'd10; fire4_y = 6'd7;
    cycle(1'b1);
    check_val("quad_life", life, 1);
    cycle(1'b0);
    fires_away();

    // Three spaced hits from a fresh game
    do_restart();
    for (int h = 0; h < 3; h++) begin
      fire1_x = 7'd11; fire1_y = 6'd6;
      tick_n(1);
      fires_away();
      tick_n(7);
    end
    check_val("lost_life", life, 0);
    check_val("lost_flag", lose, 1);
    check_val("lost_freeze", freeze, 1);
    fire2_x = 7'd10; fire2_y = 6'd7;
    tick_n(3);
    check_val("lost_hold", life, 0);
    do_restart();
    check_val("restart_life", life, 3);
    check_val("restart_lose", lose, 0);

    // Goal beats a simultaneous hit
    fires_away();
    char_x = 7'd91; char_y = 6'd59; fire1_x = 7'd91; fire1_y = 6'd59;
    cycle(1'b1);
    check_val("goal_win", win, 1);
    check_val("goal_life", life, 3);
    check_val("goal_pulse", hit_pulse, 0);
    cycle(1'b0);

    // Reset aborts cooldown mid-way
    do_restart();
    char_x = 7'd10; char_y = 6'd7; fire1_x = 7'd10; fire1_y = 6'd7;
    tick_n(4);
    check_val("mid_cd", cd_cnt, 3);
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;
    check_val("abort_cd", cd_cnt, 0);
    check_val("abort_cool", cooldown, 0);
    check_val("abort_life", life, 3);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      restart = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) begin
        char_x = 7'($urandom_range(88, 127));
        char_y = 6'($urandom_range(56, 63));
      end else begin
        char_x = 7'($urandom_range(0, 110));
        char_y = 6'($urandom_range(0, 55));
      end
      fire1_x = ($urandom_range(0, 3) == 0) ? near7(char_x) : 7'($urandom_range(0, 127));
      fire1_y = near6(char_y);
      fire2_x = ($urandom_range(0, 5) == 0) ? near7(char_x) : 7'($urandom_range(0, 127));
      fire2_y = 6'($urandom_range(0, 63));
      fire3_x = near7(char_x);
      fire3_y = ($urandom_range(0, 5) == 0) ? near6(char_y) : 6'($urandom_range(0, 63));
      fire4_x = 7'($urandom_range(0, 127));
      fire4_y = 6'($urandom_range(0, 63));
      cycle(logic'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Gameplay sequencer for the snowball/fireball screen. Each frame tick it checks the snowball against the four fireballs and the goal corner, then updates lives, the post-hit cooldown and the win/lose outcome. Its registered outputs drive the `life`, `win`, `cooldown` and `cd_cnt` inputs of the pixel renderer. Its `freeze` output halts the movement logic.

## Interface

Parameters:
- `LIFE_INIT`, 3: lives loaded at reset/restart (2-bit)
- `CD_TICKS`, 6: cooldown length in frame ticks (1..7)
- `GOAL_X`, 90: snowball `char_x` ≥ this is inside the goal region
- `GOAL_Y`, 58: snowball `char_y` ≥ this is inside the goal region
- `HIT_R`, 3: collision reach; hit when |dx| ≤ HIT_R and |dy| ≤ HIT_R

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock
- `reset`, in, 1: synchronous, active-high reset
- `frame_tick`, in, 1: one-cycle pulse, once per game frame
- `restart`, in, 1: level-sensitive; start a new game
- `char_x`, in, 7: snowball centre x
- `char_y`, in, 6: snowball centre y
- `fire1_x` … `fire4_x`, in, 7 each: fireball centre x
- `fire1_y` … `fire4_y`, in, 6 each: fireball centre y
- `life`, out, 2: remaining lives
- `win`, out, 1: game won
- `lose`, out, 1: game lost
- `cooldown`, out, 1: invulnerable after a hit
- `cd_cnt`, out, 3: cooldown ticks remaining (renderer blinks on bit 1)
- `freeze`, out, 1: stop movement; equals `win | lose`
- `hit_pulse`, out, 1: one-cycle pulse on each accepted hit

## Operation

- FSM states: PLAY, COOL, WON, LOST. All outputs are registered.
- Reset, or `restart` = 1 in any state, gives: state PLAY, `life` = LIFE_INIT, `cd_cnt` = 0, `win` = 0, `lose` = 0, `cooldown` = 0, `freeze` = 0, `hit_pulse` = 0.
  - `reset` has priority over `restart`.
- Evaluation happens only in cycles where `frame_tick` = 1. Between ticks, state holds.
- Collision test, per fireball:
  - zero-extend both coordinates to 8 bits, subtract as signed, take the absolute value, compare with HIT_R.
  - `any_hit` = OR of the four fireball results.
- Goal test: `at_goal` = (`char_x` ≥ GOAL_X) && (`char_y` ≥ GOAL_Y).
- PLAY on a tick:
  - `at_goal` → WON, `win` = 1. Goal has priority over a simultaneous hit.
  - else `any_hit` with `life` = 1 → LOST, `life` = 0, `lose` = 1, `hit_pulse` = 1.
  - else `any_hit` → COOL, `life` decrements by 1, `cd_cnt` = CD_TICKS, `cooldown` = 1, `hit_pulse` = 1.
- Several fireballs overlapping in the same tick cost one life only.
- COOL on a tick:
  - hits are ignored.
  - `at_goal` → WON. `cd_cnt` is cleared and `cooldown` = 0.
  - else `cd_cnt` decrements. On reaching 0, return to PLAY and set `cooldown` = 0.
- WON / LOST are terminal until `restart` or `reset`. `freeze` = 1.
- `life` never wraps below 0 and never exceeds LIFE_INIT.

## Timing

- All outputs update one cycle after the `frame_tick` cycle that caused the change.
- `hit_pulse` is high for exactly that one cycle.
- A hit at tick N gives `cooldown` = 1 from cycle N+1. PLAY resumes after CD_TICKS further ticks. The first tick that can register a new hit is tick N+CD_TICKS+1.
- Reset or `restart` during COOL aborts the cooldown within one cycle.
- `restart` held across a `frame_tick` keeps the block in its reset values. Play starts on the first tick after `restart` falls.
- Coordinates are sampled only in the `frame_tick` cycle. They may change freely in other cycles.

## Structure

- Package `game_pkg`:
  - state enum (PLAY/COOL/WON/LOST)
  - LIFE_INIT, CD_TICKS and the goal/HIT_R defaults
  - colour constants shared with the renderer
- Sub-module `hit_detect`: combinational abs-difference compare of one fireball against the snowball, parameterised by HIT_R. Instantiated four times.
- Top level contains the FSM, the life counter and the cooldown counter.

## Test plan

- Reset, then 10 ticks with snowball at (10,7) and all fireballs at (50,30) → `life` = 3, all flags 0, state PLAY.
- Fireball1 moved to (13,10), i.e. |dx| = |dy| = 3 → `hit_pulse` one cycle, `life` = 2, `cd_cnt` counts 6..0 over 6 ticks. An overlap held through the cooldown causes no further loss. At (14,7) there is no hit.
- All four fireballs on the snowball in one tick → `life` decrements by exactly 1.
- Three spaced hits from LIFE_INIT = 3 → `life` = 0, `lose` = 1, `freeze` = 1. Further hits change nothing. `restart` → `life` = 3, PLAY.
- Snowball at (91,59) with fireball1 on it in the same tick → `win` = 1, `life` unchanged, `hit_pulse` = 0.
- `reset` asserted mid-COOL with `cd_cnt` = 3 → next cycle `cd_cnt` = 0, `cooldown` = 0, `life` = 3.
